cp0: RTL and testbench

Coprocessor-0 for the P7 pipelined MIPS core: it sits beside the M stage and receives the interrupt and exception requests that the core's environment produces. It holds SR (12), Cause (13) and EPC (14). It raises `Req` when an enabled hardware interrupt or an exception must be taken, and it saves the victim PC into EPC. The NPC logic uses `Req` to redirect fetch to 0x0000_4180, and `eret` uses `EPCOut` to return.

---
 rtl/cp0.sv | 98 +++++++++
 tb/tb_cp0.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/cp0.sv
// Coprocessor-0 for the P7 MIPS pipeline. It holds SR, Cause and EPC and raises Req for interrupts and exceptions.
// Optional macro CP0_PRID_EN adds a read-only PRId register (number 15).
module cp0 #(
  parameter logic [31:0] HANDLER_ADDR = 32'h0000_4180
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  A1,
  input  logic [4:0]  A2,
  input  logic [31:0] DIn,
  input  logic        we,
  input  logic [31:0] VPC,
  input  logic        BDIn,
  input  logic [4:0]  ExcCodeIn,
  input  logic [5:0]  HWInt,
  input  logic        EXLClr,
  output logic        Req,
  output logic [31:0] EPCOut,
  output logic [31:0] DOut
);

  logic [5:0]  im;
  logic        exl;
  logic        ie;
  logic        bd;
  logic [5:0]  ip;
  logic [4:0]  exc_code;
  logic [31:0] epc;

  logic [31:0] sr_val;
  logic [31:0] cause_val;
  logic [31:0] rd_val;
  logic        int_req;
  logic        exc_req;
  logic        req;

  // Fetch redirects straight to HANDLER_ADDR, so a misaligned value elaborates this marker block.
  if (HANDLER_ADDR[1:0] != 2'b00) begin : g_misaligned_handler_addr
  end

  assign sr_val    = {16'b0, im, 8'b0, exl, ie};
  assign cause_val = {bd, 15'b0, ip, 3'b0, exc_code, 2'b0};

  assign int_req = ie & ~exl & (|(HWInt & im));
  assign exc_req = ~exl & (ExcCodeIn != 5'd0);
  assign req     = ~reset & (int_req | exc_req);

  always_comb begin
    rd_val = 32'b0;
    case (A1)
      5'd12:   rd_val = sr_val;
      5'd13:   rd_val = cause_val;
      5'd14:   rd_val = epc;
`ifdef CP0_PRID_EN
      5'd15:   rd_val = 32'h0000_5037;
`endif
      default: rd_val = 32'b0;
    endcase
  end

  assign Req    = req;
  assign EPCOut = reset ? 32'b0 : epc;
  assign DOut   = reset ? 32'b0 : rd_val;

  // A taken request discards a colliding mtc0/eret: the victim instruction re-executes after the handler.
  always_ff @(posedge clk) begin
    if (reset) begin
      im       <= 6'b0;
      exl      <= 1'b0;
      ie       <= 1'b0;
      bd       <= 1'b0;
      ip       <= 6'b0;
      exc_code <= 5'b0;
      epc      <= 32'b0;
    end else begin
      ip <= HWInt;
      if (req) begin
        exl      <= 1'b1;
        exc_code <= int_req ? 5'd0 : ExcCodeIn;
        bd       <= BDIn;
        epc      <= BDIn ? (VPC - 32'd4) : VPC;
      end else begin
        if (we && A2 == 5'd12) begin
          im  <= DIn[15:10];
          exl <= DIn[1];
          ie  <= DIn[0];
        end
        if (we && A2 == 5'd14) begin
          epc <= {DIn[31:2], 2'b00};
        end
        if (EXLClr) begin
          exl <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_cp0.sv
// Directed bench for cp0: reset, interrupts, delay-slot exceptions, priority, eret collisions and register decode.
// Inputs change only after a rising edge; outputs are sampled #1 after the inputs settle.
module tb_cp0;

  logic        clk;
  logic        reset;
  logic [4:0]  A1;
  logic [4:0]  A2;
  logic [31:0] DIn;
  logic        we;
  logic [31:0] VPC;
  logic        BDIn;
  logic [4:0]  ExcCodeIn;
  logic [5:0]  HWInt;
  logic        EXLClr;
  logic        Req;
  logic [31:0] EPCOut;
  logic [31:0] DOut;

  int errors = 0;
  int checks = 0;

`ifdef CP0_PRID_EN
  localparam logic [31:0] PRID_EXP = 32'h0000_5037;
`else
  localparam logic [31:0] PRID_EXP = 32'h0000_0000;
`endif

  cp0 dut (
    .clk(clk), .reset(reset), .A1(A1), .A2(A2), .DIn(DIn), .we(we),
    .VPC(VPC), .BDIn(BDIn), .ExcCodeIn(ExcCodeIn), .HWInt(HWInt),
    .EXLClr(EXLClr), .Req(Req), .EPCOut(EPCOut), .DOut(DOut)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    we = 1'b0; A2 = 5'd0; DIn = 32'b0; VPC = 32'h3000; BDIn = 1'b0;
    ExcCodeIn = 5'd0; EXLClr = 1'b0;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    #1;
  endtask

  task automatic read_reg(input logic [4:0] num, input logic [31:0] exp, input string name);
    A1 = num;
    #1;
    checks++;
    if (DOut !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, DOut, exp);
    end
  endtask

  task automatic expect_req(input logic exp, input string name);
    #1;
    checks++;
    if (Req !== exp) begin
      errors++;
      $display("[TB] FAIL %s: Req got %b expected %b", name, Req, exp);
    end
  endtask

  task automatic test_reset();
    drive_idle();
    A1 = 5'd12;
    HWInt = 6'b000100;
    reset = 1'b1;
    tick();
    #1;
    checks++;
    if (Req !== 1'b0 || EPCOut !== 32'b0 || DOut !== 32'b0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: Req=%b EPCOut=%h DOut=%h expected 0/0/0", Req, EPCOut, DOut);
    end
    tick();
    reset = 1'b0;
    read_reg(5'd12, 32'h0, "reset_sr");
    read_reg(5'd13, 32'h0, "reset_cause");
    read_reg(5'd14, 32'h0, "reset_epc");
    expect_req(1'b0, "reset_req_masked");
  endtask

  task automatic test_interrupt();
    drive_idle();
    HWInt = 6'b000000;
    we = 1'b1; A2 = 5'd12; DIn = 32'h0000_1001;
    expect_req(1'b0, "int_mtc0_cycle");
    tick();
    we = 1'b0;
    HWInt = 6'b000100;
    VPC = 32'h3010;
    expect_req(1'b1, "int_req");
    tick();
    drive_idle();
    read_reg(5'd14, 32'h0000_3010, "int_epc");
    checks++;
    if (EPCOut !== 32'h0000_3010) begin
      errors++;
      $display("[TB] FAIL int_epcout: got %h expected %h", EPCOut, 32'h0000_3010);
    end
    read_reg(5'd13, 32'h0000_1000, "int_cause");
    read_reg(5'd12, 32'h0000_1003, "int_sr");
    expect_req(1'b0, "int_no_nesting");
  endtask

  task automatic test_delay_slot_exception();
    pulse_reset();
    drive_idle();
    HWInt = 6'b0;
    ExcCodeIn = 5'd4; BDIn = 1'b1; VPC = 32'h3024;
    expect_req(1'b1, "ds_exc_req");
    tick();
    drive_idle();
    read_reg(5'd14, 32'h0000_3020, "ds_epc");
    read_reg(5'd13, 32'h8000_0010, "ds_cause");
    read_reg(5'd12, 32'h0000_0002, "ds_sr_exl");
  endtask

  task automatic test_priority();
    pulse_reset();
    drive_idle();
    HWInt = 6'b0;
    we = 1'b1; A2 = 5'd12; DIn = 32'h0000_1001;
    tick();
    drive_idle();
    HWInt = 6'b000100; ExcCodeIn = 5'd10; VPC = 32'h3100;
    expect_req(1'b1, "prio_req");
    tick();
    drive_idle();
    read_reg(5'd13, 32'h0000_1000, "prio_int_wins");

    pulse_reset();
    drive_idle();
    HWInt = 6'b0;
    we = 1'b1; A2 = 5'd12; DIn = 32'h0000_0001;
    tick();
    drive_idle();
    HWInt = 6'b000100; ExcCodeIn = 5'd10; VPC = 32'h3104;
    expect_req(1'b1, "masked_exc_req");
    tick();
    read_reg(5'd13, 32'h0000_1028, "masked_exc_cause");
    expect_req(1'b0, "exl_blocks_exc");
    drive_idle();
    HWInt = 6'b0;
  endtask

  task automatic test_eret_collision();
    drive_idle();
    HWInt = 6'b0;
    EXLClr = 1'b1;
    expect_req(1'b0, "eret_cycle");
    tick();
    drive_idle();
    read_reg(5'd12, 32'h0000_0001, "eret_clears_exl");
    ExcCodeIn = 5'd3; VPC = 32'h3200;
    expect_req(1'b1, "eret_reevaluate");
    we = 1'b1; A2 = 5'd14; DIn = 32'h0000_5000; EXLClr = 1'b1;
    tick();
    drive_idle();
    read_reg(5'd14, 32'h0000_3200, "collide_epc");
    read_reg(5'd12, 32'h0000_0003, "collide_exl_kept");
    read_reg(5'd13, 32'h0000_000C, "collide_cause");

    pulse_reset();
    drive_idle();
    HWInt = 6'b000100;
    we = 1'b1; A2 = 5'd12; DIn = 32'h0000_1001;
    expect_req(1'b0, "ie_same_cycle");
    tick();
    we = 1'b0;
    expect_req(1'b1, "ie_next_cycle");
    HWInt = 6'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    pulse_reset();
    drive_idle();
    HWInt = 6'b0;
    we = 1'b1; A2 = 5'd14; DIn = 32'h1234_5677;
    tick();
    A2 = 5'd12; DIn = 32'hFFFF_FFFF;
    tick();
    A2 = 5'd13; DIn = 32'hFFFF_FFFF;
    tick();
    A2 = 5'd15; DIn = 32'hFFFF_FFFF;
    tick();
    drive_idle();
    read_reg(5'd14, 32'h1234_5674, "mtc0_epc_aligned");
    read_reg(5'd12, 32'h0000_FC03, "mtc0_sr_masked");
    read_reg(5'd13, 32'h0000_0000, "mtc0_cause_ignored");
    read_reg(5'd15, PRID_EXP, "prid_read");
    read_reg(5'd20, 32'h0000_0000, "unmapped_read");

    HWInt = 6'b000100;
    expect_req(1'b0, "exl_blocks_int");
    pulse_reset();
    expect_req(1'b0, "mid_handler_reset_req");
    read_reg(5'd12, 32'h0000_0000, "mid_handler_reset_sr");
    HWInt = 6'b0;
  endtask

  initial begin
    reset = 1'b1;
    A1 = 5'd0;
    HWInt = 6'b0;
    drive_idle();
    test_reset();
    test_interrupt();
    test_delay_slot_exception();
    test_priority();
    test_eret_collision();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
